block_frame_assembler: RTL

- Receives framed image blocks from a UART byte stream and reassembles them into a frame in an external write-only RAM. Packets may arrive in any order.
- Each packet is checked against a checksum. Every packet gets a 2-byte ACK/NAK reply, so the host can retransmit bad blocks.
- Sits between uart_rx_module and the image-processing chain (sobel/hough). Signals frame_done when all blocks are present and holds the frame until frame_release.

---
 rtl/block_frame_assembler_if.sv | 31 +++
 rtl/block_frame_assembler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/block_frame_assembler_if.sv
// Bundled UART-side, RAM-side, response and frame-control signals of the block frame assembler.
// The assembler connects through the slave modport; the host/environment uses master.
interface block_frame_assembler_if #(
    parameter int unsigned AW = 10
);
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    rsp_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          frame_done;
    logic          frame_locked;
    logic          frame_release;
    logic [7:0]    blocks_ok;
    logic [7:0]    err_count;

    modport slave (
        input  rx_data, rx_valid, rsp_ready, frame_release,
        output mem_we, mem_addr, mem_wdata, rsp_data, rsp_valid,
        output frame_done, frame_locked, blocks_ok, err_count
    );

    modport master (
        output rx_data, rx_valid, rsp_ready, frame_release,
        input  mem_we, mem_addr, mem_wdata, rsp_data, rsp_valid,
        input  frame_done, frame_locked, blocks_ok, err_count
    );
endinterface

// File: rtl/block_frame_assembler.sv
// Parses 0xAA/id/total/payload/chk/0x55 block packets from a byte stream, writes payload into
// a row-major frame RAM, answers every packet with ACK/NAK and tracks frame completion.
module block_frame_assembler #(
    parameter int unsigned IMG_W       = 32,
    parameter int unsigned IMG_H       = 32,
    parameter int unsigned BLK_W       = 8,
    parameter int unsigned BLK_H       = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input logic                   clk,
    input logic                   reset_n,
    block_frame_assembler_if.slave bus
);
    localparam int unsigned NBC  = IMG_W / BLK_W;
    localparam int unsigned NBLK = NBC * (IMG_H / BLK_H);
    localparam int unsigned AW   = $clog2(IMG_W * IMG_H);
    localparam int unsigned LCW  = (BLK_W > 1) ? $clog2(BLK_W) : 1;
    localparam int unsigned LRW  = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        StIdle, StId, StTotal, StPayload, StChk, StFooter
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      id_q, id_d;
    logic [7:0]      xor_q, xor_d;
    logic [7:0]      chk_q, chk_d;
    logic            blk_ok_q, blk_ok_d;
    logic            in_range_q, in_range_d;
    logic [LCW-1:0]  lc_q, lc_d;
    logic [LRW-1:0]  lr_q, lr_d;
    logic [AW-1:0]   row_base_q, row_base_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]      mem_wdata_q, mem_wdata_d;
    logic [NBLK-1:0] bitmap_q, bitmap_d;
    logic [7:0]      blocks_ok_q, blocks_ok_d;
    logic [7:0]      err_q, err_d;
    logic            done_q, done_d;
    logic            locked_q, locked_d;
    logic [7:0]      rsp0_q, rsp0_d;
    logic [7:0]      rsp1_q, rsp1_d;
    logic [1:0]      rsp_cnt_q, rsp_cnt_d;

    logic [NBLK-1:0] id_onehot;
    logic            timeout_hit;
    logic            rsp_push;
    logic [7:0]      rsp_code;
    logic [7:0]      rsp_id;
    logic            err_inc;
    logic            was_set;

    always_comb begin
        id_onehot = '0;
        for (int unsigned i = 0; i < NBLK; i++) begin
            id_onehot[i] = (32'(id_q) == i);
        end
    end

    assign was_set     = |(bitmap_q & id_onehot);
    assign timeout_hit = (state_q != StIdle) && !bus.rx_valid &&
                         (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        xor_d       = xor_q;
        chk_d       = chk_q;
        blk_ok_d    = blk_ok_q;
        in_range_d  = in_range_q;
        lc_d        = lc_q;
        lr_d        = lr_q;
        row_base_d  = row_base_q;
        tmo_d       = tmo_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        bitmap_d    = bitmap_q;
        blocks_ok_d = blocks_ok_q;
        err_d       = err_q;
        done_d      = 1'b0;
        locked_d    = locked_q | done_q;
        rsp0_d      = rsp0_q;
        rsp1_d      = rsp1_q;
        rsp_cnt_d   = rsp_cnt_q;
        rsp_push    = 1'b0;
        rsp_code    = 8'h00;
        rsp_id      = 8'h00;
        err_inc     = 1'b0;

        if (state_q == StIdle || bus.rx_valid) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (timeout_hit) begin
            state_d = StIdle;
            tmo_d   = '0;
            err_inc = 1'b1;
        end else if (bus.rx_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.rx_data == 8'hAA) state_d = StId;
                end
                StId: begin
                    id_d    = bus.rx_data;
                    xor_d   = bus.rx_data;
                    state_d = StTotal;
                end
                StTotal: begin
                    xor_d      = xor_q ^ bus.rx_data;
                    in_range_d = 32'(id_q) < NBLK;
                    blk_ok_d   = (32'(id_q) < NBLK) && (bus.rx_data == 8'(NBLK)) && !locked_q;
                    // Block origin resolved once here so the payload path only adds and counts.
                    row_base_d = AW'((32'(id_q) / NBC) * BLK_H * IMG_W
                                     + (32'(id_q) % NBC) * BLK_W);
                    lc_d       = '0;
                    lr_d       = '0;
                    state_d    = StPayload;
                end
                StPayload: begin
                    xor_d       = xor_q ^ bus.rx_data;
                    mem_we_d    = blk_ok_q;
                    mem_addr_d  = row_base_q + AW'(lc_q);
                    mem_wdata_d = bus.rx_data;
                    if (lc_q == LCW'(BLK_W - 1)) begin
                        lc_d       = '0;
                        row_base_d = row_base_q + AW'(IMG_W);
                        if (lr_q == LRW'(BLK_H - 1)) begin
                            state_d = StChk;
                        end else begin
                            lr_d = lr_q + LRW'(1);
                        end
                    end else begin
                        lc_d = lc_q + LCW'(1);
                    end
                end
                StChk: begin
                    chk_d   = bus.rx_data;
                    state_d = StFooter;
                end
                StFooter: begin
                    state_d  = StIdle;
                    rsp_push = 1'b1;
                    if (bus.rx_data == 8'h55 && chk_q == xor_q && blk_ok_q && !locked_q) begin
                        rsp_code = 8'h06;
                        rsp_id   = id_q;
                        bitmap_d = bitmap_q | id_onehot;
                        if (!was_set) begin
                            blocks_ok_d = blocks_ok_q + 8'd1;
                            done_d      = &(bitmap_q | id_onehot);
                        end
                    end else begin
                        err_inc  = 1'b1;
                        rsp_code = locked_q ? 8'h16 : 8'h15;
                        rsp_id   = (locked_q || in_range_q) ? id_q : 8'hFF;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;

        // Release wins over a completion in the same cycle: frame is cleared, never locked.
        if (bus.frame_release && state_q != StPayload) begin
            bitmap_d    = '0;
            blocks_ok_d = 8'd0;
            locked_d    = 1'b0;
            done_d      = 1'b0;
        end

        // A new response overwrites whatever is left of the previous one.
        if (rsp_push) begin
            rsp0_d    = rsp_code;
            rsp1_d    = rsp_id;
            rsp_cnt_d = 2'd2;
        end else if (rsp_cnt_q != 2'd0 && bus.rsp_ready) begin
            rsp0_d    = rsp1_q;
            rsp1_d    = 8'h00;
            rsp_cnt_d = rsp_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            id_q        <= 8'h00;
            xor_q       <= 8'h00;
            chk_q       <= 8'h00;
            blk_ok_q    <= 1'b0;
            in_range_q  <= 1'b0;
            lc_q        <= '0;
            lr_q        <= '0;
            row_base_q  <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            bitmap_q    <= '0;
            blocks_ok_q <= 8'h00;
            err_q       <= 8'h00;
            done_q      <= 1'b0;
            locked_q    <= 1'b0;
            rsp0_q      <= 8'h00;
            rsp1_q      <= 8'h00;
            rsp_cnt_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            xor_q       <= xor_d;
            chk_q       <= chk_d;
            blk_ok_q    <= blk_ok_d;
            in_range_q  <= in_range_d;
            lc_q        <= lc_d;
            lr_q        <= lr_d;
            row_base_q  <= row_base_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            bitmap_q    <= bitmap_d;
            blocks_ok_q <= blocks_ok_d;
            err_q       <= err_d;
            done_q      <= done_d;
            locked_q    <= locked_d;
            rsp0_q      <= rsp0_d;
            rsp1_q      <= rsp1_d;
            rsp_cnt_q   <= rsp_cnt_d;
        end
    end

    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.rsp_data     = rsp0_q;
    assign bus.rsp_valid    = (rsp_cnt_q != 2'd0);
    assign bus.frame_done   = done_q;
    assign bus.frame_locked = locked_q;
    assign bus.blocks_ok    = blocks_ok_q;
    assign bus.err_count    = err_q;

endmodule
